// File: rtl/seq_alu_if.sv
// Handshaked request/response bundle for seq_alu: operands and opcode in,
// registered result and flags out.
interface seq_alu_if #(
  parameter int unsigned NUMBITS = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         opcode;
  logic [NUMBITS-1:0] A;
  logic [NUMBITS-1:0] B;
  logic               out_valid;
  logic               out_ready;
  logic [NUMBITS-1:0] result;
  logic               carryout;
  logic               overflow;
  logic               zero;
  logic               illegal;
  logic               busy;

  modport master (
    output in_valid, opcode, A, B, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero, illegal, busy
  );

  modport slave (
    input  in_valid, opcode, A, B, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero, illegal, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial shifts and an
// optional shift-add multiply (enabled by defining SEQ_ALU_MUL_EN).
module seq_alu #(
  parameter int unsigned NUMBITS = 16,
  parameter int unsigned SHW     = $clog2(NUMBITS)
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADDU = 4'h0, OP_ADDS = 4'h1, OP_SUBU = 4'h2, OP_SUBS = 4'h3,
    OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_SRA  = 4'h7,
    OP_SLL  = 4'h8, OP_MUL  = 4'h9
  } op_t;

  localparam int unsigned MSB = NUMBITS - 1;

  state_t             r_state;
  logic [NUMBITS-1:0] r_acc;
  logic [SHW:0]       r_cnt;
  logic               r_is_sll;
  logic [NUMBITS-1:0] r_result;
  logic               r_carry, r_ovf, r_zero, r_illegal;
  logic               r_out_valid, r_in_ready, r_busy;

  logic [NUMBITS:0]   w_sum, w_diff;
  logic [NUMBITS-1:0] w_res;
  logic               w_carry, w_ovf, w_illegal, w_multi;
  logic [NUMBITS-1:0] w_shift;
  logic [NUMBITS-1:0] w_exec_res;
  logic               w_exec_ovf;
  logic               w_is_mul;

  always_comb begin
    w_sum     = {1'b0, bus.A} + {1'b0, bus.B};
    w_diff    = {1'b0, bus.A} - {1'b0, bus.B};
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    w_multi   = 1'b0;
    case (bus.opcode)
      OP_ADDU: begin
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[NUMBITS];
      end
      OP_ADDS: begin
        w_res = w_sum[MSB:0];
        w_ovf = (bus.A[MSB] == bus.B[MSB]) && (w_sum[MSB] != bus.A[MSB]);
      end
      OP_SUBU: begin
        w_res   = w_diff[MSB:0];
        w_carry = w_diff[NUMBITS];
      end
      OP_SUBS: begin
        w_res = w_diff[MSB:0];
        w_ovf = (bus.A[MSB] != bus.B[MSB]) && (w_diff[MSB] != bus.A[MSB]);
      end
      OP_AND: w_res = bus.A & bus.B;
      OP_OR:  w_res = bus.A | bus.B;
      OP_XOR: w_res = bus.A ^ bus.B;
      OP_SRA, OP_SLL: begin
        if (bus.B[SHW-1:0] == '0) w_res = bus.A;
        else                      w_multi = 1'b1;
      end
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: w_multi = 1'b1;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_shift = r_is_sll ? {r_acc[MSB-1:0], 1'b0} : {r_acc[MSB], r_acc[MSB:1]};
  end

`ifdef SEQ_ALU_MUL_EN
  logic               r_is_mul;
  logic [NUMBITS-1:0] r_hi;
  logic [NUMBITS-1:0] r_mcand;
  logic [NUMBITS:0]   w_psum;
  logic [NUMBITS-1:0] w_hi_next, w_lo_next;

  // {r_hi, r_acc} is the running product; the multiplier is consumed from r_acc[0]
  always_comb begin
    w_psum     = {1'b0, r_hi} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_hi_next  = w_psum[NUMBITS:1];
    w_lo_next  = {w_psum[0], r_acc[MSB:1]};
    w_is_mul   = r_is_mul;
    w_exec_res = r_is_mul ? w_lo_next : w_shift;
    w_exec_ovf = r_is_mul && (w_hi_next != '0);
  end
`else
  always_comb begin
    w_is_mul   = 1'b0;
    w_exec_res = w_shift;
    w_exec_ovf = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_is_sll    <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      r_is_mul    <= 1'b0;
      r_hi        <= '0;
      r_mcand     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_is_sll   <= (bus.opcode == OP_SLL);
            r_acc      <= bus.A;
            r_cnt      <= {1'b0, bus.B[SHW-1:0]};
`ifdef SEQ_ALU_MUL_EN
            r_is_mul   <= (bus.opcode == OP_MUL);
            r_hi       <= '0;
            r_mcand    <= bus.A;
            if (bus.opcode == OP_MUL) begin
              r_acc <= bus.B;
              r_cnt <= (SHW+1)'(NUMBITS);
            end
`endif
            if (w_multi) begin
              r_state   <= EXEC;
              r_carry   <= 1'b0;
              r_ovf     <= 1'b0;
              r_illegal <= 1'b0;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_carry     <= w_carry;
              r_ovf       <= w_ovf;
              r_illegal   <= w_illegal;
              r_zero      <= (w_res == '0);
            end
          end
        end
        EXEC: begin
          r_cnt <= r_cnt - (SHW+1)'(1);
`ifdef SEQ_ALU_MUL_EN
          if (r_is_mul) begin
            r_hi  <= w_hi_next;
            r_acc <= w_lo_next;
          end else begin
            r_acc <= w_shift;
          end
`else
          r_acc <= w_shift;
`endif
          // For SLL the last bit shifted out is the MSB before the final step
          r_carry <= r_is_sll && !w_is_mul && r_acc[MSB];
          if (r_cnt == (SHW+1)'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_exec_res;
            r_ovf       <= w_exec_ovf;
            r_zero      <= (w_exec_res == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carryout  = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (NUMBITS=16): directed vector table,
// reset/backpressure sequences and randomized ops against a reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.NUMBITS(16)) bif ();
  seq_alu #(.NUMBITS(16)) dut (.clk(clk), .reset(reset), .bus(bif));

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        ill;
  } out_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    out_t        eo;
    int          lat;
    int          hold;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model from the opcode definitions, using plain wide arithmetic
  function automatic out_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, output int lat);
    logic [31:0]        w;
    logic signed [15:0] sa;
    int                 n;
    out_t               e;
    e   = '0;
    lat = 1;
    n   = int'(b[3:0]);
    sa  = a;
    case (op)
      4'h0: begin w = a + b; e.res = w[15:0]; e.c = w[16]; end
      4'h1: begin w = a + b; e.res = w[15:0]; e.v = (a[15] == b[15]) && (w[15] != a[15]); end
      4'h2: begin e.res = a - b; e.c = (a < b); end
      4'h3: begin e.res = a - b; e.v = (a[15] != b[15]) && (e.res[15] != a[15]); end
      4'h4: e.res = a & b;
      4'h5: e.res = a | b;
      4'h6: e.res = a ^ b;
      4'h7: begin e.res = sa >>> n; lat = (n == 0) ? 1 : n + 1; end
      4'h8: begin w = {16'h0, a} << n; e.res = w[15:0]; e.c = w[16]; lat = (n == 0) ? 1 : n + 1; end
`ifdef SEQ_ALU_MUL_EN
      4'h9: begin w = a * b; e.res = w[15:0]; e.v = (w[31:16] != 0); lat = 17; end
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 16'h0);
    return e;
  endfunction

  task automatic run_op(input string nm, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input out_t eo, input int elat, input int hold);
    int   lat;
    bit   stall_bad;
    bit   hold_bad;
    out_t act, snap;
    stall_bad = 1'b0;
    hold_bad  = 1'b0;
    chk({nm, ".in_ready"}, 32'(bif.in_ready), 32'd1);
    bif.in_valid  = 1'b1;
    bif.opcode    = op;
    bif.A         = a;
    bif.B         = b;
    bif.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // new request and scrambled operands must be ignored while busy
    bif.opcode = 4'($urandom);
    bif.A      = 16'($urandom);
    bif.B      = 16'($urandom);
    lat = 1;
    while (!bif.out_valid && lat < 40) begin
      if (bif.in_ready !== 1'b0 || bif.busy !== 1'b1) stall_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    act = {bif.result, bif.carryout, bif.overflow, bif.zero, bif.illegal};
    chk({nm, ".latency"}, 32'(lat), 32'(elat));
    chk({nm, ".outputs"}, 32'(act), 32'(eo));
    chk({nm, ".stall"}, {31'd0, stall_bad}, 32'd0);
    snap = act;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      act = {bif.result, bif.carryout, bif.overflow, bif.zero, bif.illegal};
      if (act !== snap || bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0) hold_bad = 1'b1;
    end
    if (hold > 0) chk({nm, ".hold"}, {31'd0, hold_bad}, 32'd0);
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    chk({nm, ".release"}, {30'd0, bif.out_valid, bif.in_ready}, 32'd1);
  endtask

  vec_t tv[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_t eo;
    int   lat;
    bit   spurious;

    tv.push_back('{4'h0, 16'hFFFF, 16'h0001, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}, 1, 0});
    tv.push_back('{4'h1, 16'h7FFF, 16'h0001, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}, 1, 0});
    tv.push_back('{4'h3, 16'h8000, 16'h0001, {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}, 1, 1});
    tv.push_back('{4'h2, 16'h0003, 16'h0005, {16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0}, 1, 0});
    tv.push_back('{4'h7, 16'h8000, 16'h0004, {16'hF800, 1'b0, 1'b0, 1'b0, 1'b0}, 5, 0});
    tv.push_back('{4'h7, 16'h8000, 16'h0000, {16'h8000, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0});
`ifdef SEQ_ALU_MUL_EN
    tv.push_back('{4'h9, 16'h0100, 16'h0100, {16'h0000, 1'b0, 1'b1, 1'b1, 1'b0}, 17, 0});
    tv.push_back('{4'h9, 16'h00FF, 16'h0003, {16'h02FD, 1'b0, 1'b0, 1'b0, 1'b0}, 17, 0});
`else
    tv.push_back('{4'h9, 16'h0100, 16'h0100, {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1}, 1, 0});
`endif
    tv.push_back('{4'h4, 16'hF0F0, 16'hFF00, {16'hF000, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 3});
    tv.push_back('{4'h5, 16'h0F00, 16'h00F0, {16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0});
    tv.push_back('{4'h6, 16'h1234, 16'h1234, {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}, 1, 0});
    tv.push_back('{4'h8, 16'h8001, 16'h0001, {16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}, 2, 0});
    tv.push_back('{4'h8, 16'h0003, 16'h000F, {16'h8000, 1'b1, 1'b0, 1'b0, 1'b0}, 16, 3});
    tv.push_back('{4'h8, 16'h00AA, 16'h0000, {16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0});
    tv.push_back('{4'hC, 16'h0005, 16'h0006, {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1}, 1, 2});

    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.opcode    = 4'h0;
    bif.A         = 16'h0;
    bif.B         = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset.outputs", 32'({bif.result, bif.carryout, bif.overflow, bif.zero, bif.illegal}), 32'd0);
    chk("reset.handshake", {29'd0, bif.out_valid, bif.busy, bif.in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < tv.size(); i++)
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].eo, tv[i].lat, tv[i].hold);

    // Reset pulsed in the middle of an SLL by 10 must abort with no output
    bif.in_valid = 1'b1;
    bif.opcode   = 4'h8;
    bif.A        = 16'h1234;
    bif.B        = 16'h000A;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.busy_before", {31'd0, bif.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort.during", {29'd0, bif.out_valid, bif.busy, bif.illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort.after", {29'd0, bif.out_valid, bif.busy, bif.in_ready}, 32'd1);
    spurious = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) spurious = 1'b1;
    end
    bif.out_ready = 1'b0;
    chk("abort.no_output", {31'd0, spurious}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      eo = model(op, a, b, lat);
      run_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, eo, lat, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
